// File: rtl/handshake_tx.sv
// handshake_tx: 4-phase (return-to-zero) request/acknowledge sender.
//
// The local producer offers words on in_data/in_valid. A word is accepted
// when in_ready is high. It is then held on tx_data while tx_req is raised
// toward a remote receiver. That receiver's tx_ack is asynchronous to clock,
// so it only enters the FSM through a SYNC_STAGES-deep synchroniser.
//
// Optional feature: define HS_TIMEOUT_EN to compile in a wait-limit counter.
// When the limit is hit, the handshake is abandoned and the sticky err flag
// is set.
//
// Ports
//   clock     : single clock, rising edge
//   reset     : synchronous, active-high
//   in_data   : [1:N] word from producer
//   in_valid  : in_data valid
//   in_ready  : word accepted on this edge (combinational)
//   tx_data   : [1:N] registered word presented to remote receiver
//   tx_req    : registered 4-phase request
//   tx_ack    : asynchronous 4-phase acknowledge
//   busy      : handshake in progress (state != IDLE)
//   err       : sticky timeout flag (constant 0 without HS_TIMEOUT_EN)
module handshake_tx #(
    parameter int N           = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:N] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:N] tx_data,
    output logic       tx_req,
    input  logic       tx_ack,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   tx_req_q, tx_req_d;
    logic [1:N]             tx_data_q, tx_data_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_s;

    // sync_q[0] is the only flop that ever sees raw tx_ack.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], tx_ack};
    assign ack_s  = sync_q[SYNC_STAGES-1];

    // Ack still high in IDLE means the receiver has not finished the
    // previous return-to-zero phase, so new words are refused.
    assign in_ready = (state_q == IDLE) && !ack_s && !reset;
    assign busy     = (state_q != IDLE);
    assign tx_req   = tx_req_q;
    assign tx_data  = tx_data_q;

`ifdef HS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
`ifdef HS_TIMEOUT_EN
        err_d     = err_q;
        cnt_d     = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    tx_data_d = in_data;
                    tx_req_d  = 1'b1;
                    state_d   = REQ;
`ifdef HS_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            REQ: begin
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = WAIT_LOW;
`ifdef HS_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            WAIT_LOW: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
`ifdef HS_TIMEOUT_EN
        // Abandoning the handshake takes priority over a same-cycle ack.
        if (state_q != IDLE && cnt_q == CW'(TIMEOUT - 1)) begin
            tx_req_d = 1'b0;
            state_d  = IDLE;
            err_d    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            sync_q    <= '0;
`ifdef HS_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            sync_q    <= sync_d;
`ifdef HS_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_handshake_tx.sv
// Self-checking bench for handshake_tx (N=8, SYNC_STAGES=2, TIMEOUT=16).
// Directed scenarios cover reset, ack-in-IDLE, reset mid-handshake and the
// wait limit. These are followed by randomized transfers with a random
// remote receiver. Every offered word that should be sent is queued. A
// monitor pops and compares on each rising tx_req, and checks that tx_data
// stays stable while tx_req is high.
module tb_handshake_tx;
    localparam int N  = 8;
    localparam int SS = 2;
    localparam int TO = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:N] in_data = '0;
    logic       in_valid = 1'b0;
    logic       tx_ack = 1'b0;
    logic       in_ready, tx_req, busy, err;
    logic [1:N] tx_data;

    int tests = 0;
    int fails = 0;
    logic [1:N] exp_q[$];
    logic [1:N] cur = '0;
    logic       prev_req = 1'b0;

    handshake_tx #(.N(N), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx_data(tx_data), .tx_req(tx_req),
        .tx_ack(tx_ack), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic until_req_high(output int n);
        n = 0;
        do begin tick(); n++; end while (!tx_req && n < 40);
    endtask

    task automatic until_req_low(output int n);
        n = 0;
        do begin tick(); n++; end while (tx_req && n < 40);
    endtask

    task automatic until_ready(output int n);
        n = 0;
        do begin tick(); n++; end while (!in_ready && n < 40);
    endtask

    // Monitor: each new request must carry the next expected word.
    initial begin
        forever begin
            @(negedge clock);
            if (tx_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tx: got %0h expected no request", tx_data);
                end else begin
                    cur = exp_q.pop_front();
                    chk("tx_word", tx_data, cur);
                end
            end else if (tx_req) begin
                chk("tx_data_stable", tx_data, cur);
            end
            prev_req = tx_req;
        end
    end

    // One complete transfer. The receiver raises ack after d1 idle cycles
    // and drops it d2 cycles after the request falls. When junk is set, a
    // different word is offered while the handshake is busy.
    task automatic xfer(input logic [1:N] w, input int d1, input int d2, input bit junk);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        exp_q.push_back(w);
        until_req_high(n);
        chk("accept_latency", n, 1);
        in_valid = 1'b0;
        chk("tx_data_capture", tx_data, w);
        chk("busy_req", busy, 1);
        if (junk) begin
            in_data  = w ^ 8'hFF;
            in_valid = 1'b1;
            tick();
            tick();
            chk("busy_offer_ignored", tx_data, w);
            in_valid = 1'b0;
        end
        repeat (d1) tick();
        tx_ack = 1'b1;
        until_req_low(n);
        chk("req_fall_latency", n, SS + 1);
        chk("busy_wait_low", busy, 1);
        chk("tx_data_hold", tx_data, w);
        repeat (d2) tick();
        tx_ack = 1'b0;
        until_ready(n);
        chk("ready_rise_latency", n, SS + 1);
        chk("busy_back_idle", busy, 0);
    endtask

    initial begin
        int n;
        // Reset and idle state.
        reset = 1'b1;
        tick();
        chk("ready_in_reset", in_ready, 0);
        tick();
        chk("rst_tx_req", tx_req, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_release", in_ready, 1);

        // Basic transfer with an ignored offer while busy.
        xfer(8'hA5, 2, 2, 1'b1);

        // Ack high while idle blocks acceptance until it clears.
        tx_ack = 1'b1;
        repeat (3) tick();
        chk("ack_idle_ready", in_ready, 0);
        chk("ack_idle_busy", busy, 0);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        exp_q.push_back(8'h5A);
        tick();
        chk("ack_idle_no_accept", tx_req, 0);
        tx_ack = 1'b0;
        tick();
        chk("ack_low_edge1_ready", in_ready, 0);
        chk("ack_low_edge1_req", tx_req, 0);
        tick();
        tick();
        chk("ack_low_accept_req", tx_req, 1);
        chk("ack_low_accept_data", tx_data, 8'h5A);
        in_valid = 1'b0;
        tx_ack = 1'b1;
        until_req_low(n);
        chk("req_fall_latency", n, SS + 1);
        tx_ack = 1'b0;
        until_ready(n);
        chk("ready_rise_latency", n, SS + 1);

        // Reset in the middle of a handshake.
        in_data  = 8'hC3;
        in_valid = 1'b1;
        exp_q.push_back(8'hC3);
        tick();
        chk("mid_rst_req_before", tx_req, 1);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("mid_rst_req", tx_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", tx_data, 8'h00);
        reset = 1'b0;
        repeat (5) tick();
        chk("mid_rst_no_resend", tx_req, 0);

        // Acknowledge never arrives.
        in_data  = 8'hE7;
        in_valid = 1'b1;
        exp_q.push_back(8'hE7);
        tick();
        in_valid = 1'b0;
        repeat (TO - 1) tick();
        chk("req_before_limit", tx_req, 1);
        tick();
`ifdef HS_TIMEOUT_EN
        chk("timeout_req", tx_req, 0);
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 0);
        repeat (4) tick();
        chk("timeout_err_sticky", err, 1);
        chk("timeout_ready", in_ready, 1);
`else
        chk("no_timeout_req", tx_req, 1);
        chk("no_timeout_err", err, 0);
        repeat (4) tick();
        chk("no_timeout_req_later", tx_req, 1);
`endif
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("err_cleared", err, 0);
        chk("ready_after_rst2", in_ready, 1);

        // Randomized transfers; the wait delays stay well inside the limit.
        for (int i = 0; i < 20; i++) begin
            xfer(N'($urandom_range(0, 255)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
